// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/response bundle between fetch control (master) and pc_sequencer (slave)
interface pc_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic              stall;
    logic              branch;
    logic [2:0]        cond;
    logic              zero;
    logic              lt;
    logic              ltu;
    logic              jal;
    logic              jalr;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   link;
    logic              taken;
    logic              flush;
    logic              trap;
    logic [XLEN-1:0]   bad_addr;
    logic [CNT_W-1:0]  redir_cnt;

    modport master (
        output stall, branch, cond, zero, lt, ltu, jal, jalr, rs1, imm,
        input  pc, link, taken, flush, trap, bad_addr, redir_cnt
    );

    modport slave (
        input  stall, branch, cond, zero, lt, ltu, jal, jalr, rs1, imm,
        output pc, link, taken, flush, trap, bad_addr, redir_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC with branch/JAL/JALR redirect, misaligned trap, flush pulse; optional PC_PERF_EN redirect counter
module pc_sequencer #(
    parameter int               XLEN      = 32,
    parameter bit               BYTE_ADDR = 1'b0,
    parameter logic [XLEN-1:0]  RST_VEC   = '0,
    parameter logic [XLEN-1:0]  TRAP_VEC  = XLEN'('h10),
    parameter int               CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_sequencer_if.slave   bus
);

    localparam logic [XLEN-1:0] STEP = BYTE_ADDR ? XLEN'(4) : XLEN'(1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] bad_q;
    logic            flush_q;
    logic            trap_q;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_tgt;
    logic [XLEN-1:0] ind_tgt;
    logic [XLEN-1:0] tgt;
    logic            cond_ok;
    logic            redirect;
    logic            misaligned;

    // Branch condition decode from the ALU flags; 010/011 are reserved and never taken.
    always_comb begin
        cond_ok = 1'b0;
        case (bus.cond)
            3'b000:  cond_ok = bus.zero;
            3'b001:  cond_ok = !bus.zero;
            3'b100:  cond_ok = bus.lt;
            3'b101:  cond_ok = !bus.lt;
            3'b110:  cond_ok = bus.ltu;
            3'b111:  cond_ok = !bus.ltu;
            default: cond_ok = 1'b0;
        endcase
    end

    // Target select: jalr over jal over conditional branch; only redirects can be misaligned.
    always_comb begin
        seq_pc  = pc_q + STEP;
        rel_tgt = pc_q + bus.imm;
        ind_tgt = bus.rs1 + bus.imm;
        if (BYTE_ADDR) begin
            ind_tgt[0] = 1'b0;
        end
        redirect   = !bus.stall && (bus.jalr || bus.jal || (bus.branch && cond_ok));
        tgt        = bus.jalr ? ind_tgt : rel_tgt;
        misaligned = BYTE_ADDR && redirect && tgt[1];
    end

    // PC, flush/trap pulses and faulting address; stall freezes PC and drops the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RST_VEC;
            bad_q   <= '0;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
        end else if (bus.stall) begin
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
        end else if (misaligned) begin
            pc_q    <= TRAP_VEC;
            bad_q   <= tgt;
            flush_q <= 1'b1;
            trap_q  <= 1'b1;
        end else if (redirect) begin
            pc_q    <= tgt;
            flush_q <= 1'b1;
            trap_q  <= 1'b0;
        end else begin
            pc_q    <= seq_pc;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
        end
    end

`ifdef PC_PERF_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of non-stalled redirects, traps included; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.redir_cnt = cnt_q;
`else
    assign bus.redir_cnt = {CNT_W{1'b0}};
`endif

    assign bus.pc       = pc_q;
    assign bus.link     = seq_pc;
    assign bus.taken    = redirect;
    assign bus.flush    = flush_q;
    assign bus.trap     = trap_q;
    assign bus.bad_addr = bad_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer, word-addressed and byte-addressed instances
module tb_pc_sequencer;

    typedef struct packed {
        logic        stall;
        logic        branch;
        logic [2:0]  cond;
        logic        zero;
        logic        lt;
        logic        ltu;
        logic        jal;
        logic        jalr;
        logic [31:0] rs1;
        logic [31:0] imm;
    } in_t;

    typedef struct {
        int          u;
        logic [31:0] pc;
        logic [31:0] bad;
        logic        flush;
        logic        trap;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32), .CNT_W(16)) ia ();
    pc_sequencer_if #(.XLEN(32), .CNT_W(2))  ib ();

    pc_sequencer #(.XLEN(32), .BYTE_ADDR(1'b0), .RST_VEC(32'h0), .TRAP_VEC(32'h10), .CNT_W(16))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    pc_sequencer #(.XLEN(32), .BYTE_ADDR(1'b1), .RST_VEC(32'h100), .TRAP_VEC(32'h10), .CNT_W(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    int ncmp = 0;
    int nfail = 0;
    exp_t sb[$];

    logic [31:0] m_pc [2];
    logic [31:0] m_bad [2];
    logic        m_flush [2];
    logic        m_trap [2];
    int unsigned m_cnt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic in_t f_stall();
        in_t x = '0;
        x.stall = 1'b1;
        return x;
    endfunction

    function automatic in_t f_jal(input logic [31:0] im);
        in_t x = '0;
        x.jal = 1'b1;
        x.imm = im;
        return x;
    endfunction

    function automatic in_t f_jalr(input logic [31:0] r, input logic [31:0] im);
        in_t x = '0;
        x.jalr = 1'b1;
        x.rs1 = r;
        x.imm = im;
        return x;
    endfunction

    function automatic in_t f_br(input logic [2:0] c, input logic z, input logic l, input logic lu,
                                 input logic [31:0] im);
        in_t x = '0;
        x.branch = 1'b1;
        x.cond = c;
        x.zero = z;
        x.lt = l;
        x.ltu = lu;
        x.imm = im;
        return x;
    endfunction

    task automatic model_reset();
        m_pc[0] = 32'h0;
        m_pc[1] = 32'h100;
        for (int i = 0; i < 2; i++) begin
            m_bad[i] = '0;
            m_flush[i] = 1'b0;
            m_trap[i] = 1'b0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_step(input int u, input in_t x, output logic tk, output logic [31:0] lk);
        logic ok;
        logic [31:0] stp;
        logic [31:0] t;
        logic redir;
        stp = (u == 1) ? 32'd4 : 32'd1;
        case (x.cond)
            3'b000: ok = x.zero;
            3'b001: ok = ~x.zero;
            3'b100: ok = x.lt;
            3'b101: ok = ~x.lt;
            3'b110: ok = x.ltu;
            3'b111: ok = ~x.ltu;
            default: ok = 1'b0;
        endcase
        redir = ~x.stall & (x.jalr | x.jal | (x.branch & ok));
        tk = redir;
        lk = m_pc[u] + stp;
        if (x.jalr) begin
            t = x.rs1 + x.imm;
            if (u == 1) t = t & 32'hFFFF_FFFE;
        end else begin
            t = m_pc[u] + x.imm;
        end
        if (x.stall) begin
            m_flush[u] = 1'b0;
            m_trap[u] = 1'b0;
        end else if (redir) begin
            m_flush[u] = 1'b1;
            if (u == 1 && t[1]) begin
                m_pc[u] = 32'h10;
                m_bad[u] = t;
                m_trap[u] = 1'b1;
            end else begin
                m_pc[u] = t;
                m_trap[u] = 1'b0;
            end
`ifdef PC_PERF_EN
            if (m_cnt[u] < ((u == 1) ? 32'd3 : 32'd65535)) m_cnt[u] = m_cnt[u] + 1;
`endif
        end else begin
            m_pc[u] = m_pc[u] + stp;
            m_flush[u] = 1'b0;
            m_trap[u] = 1'b0;
        end
    endtask

    task automatic apply(input in_t a, input in_t b);
        ia.stall = a.stall; ia.branch = a.branch; ia.cond = a.cond; ia.zero = a.zero;
        ia.lt = a.lt; ia.ltu = a.ltu; ia.jal = a.jal; ia.jalr = a.jalr; ia.rs1 = a.rs1; ia.imm = a.imm;
        ib.stall = b.stall; ib.branch = b.branch; ib.cond = b.cond; ib.zero = b.zero;
        ib.lt = b.lt; ib.ltu = b.ltu; ib.jal = b.jal; ib.jalr = b.jalr; ib.rs1 = b.rs1; ib.imm = b.imm;
    endtask

    // One clock: drive unit u with x (other unit stalled), check combinational outputs, then registered ones.
    task automatic run(input int u, input in_t x);
        in_t xs [2];
        logic tk;
        logic [31:0] lk;
        exp_t e;
        xs[u] = x;
        xs[1-u] = f_stall();
        @(negedge clk);
        apply(xs[0], xs[1]);
        #1;
        for (int v = 0; v < 2; v++) begin
            model_step(v, xs[v], tk, lk);
            chk((v == 0) ? "a_taken" : "b_taken", (v == 0) ? 32'(ia.taken) : 32'(ib.taken), 32'(tk));
            chk((v == 0) ? "a_link" : "b_link", (v == 0) ? ia.link : ib.link, lk);
            e.u = v; e.pc = m_pc[v]; e.bad = m_bad[v]; e.flush = m_flush[v];
            e.trap = m_trap[v]; e.cnt = 16'(m_cnt[v]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.u == 0) begin
                chk("a_pc", ia.pc, e.pc);
                chk("a_flush", 32'(ia.flush), 32'(e.flush));
                chk("a_trap", 32'(ia.trap), 32'(e.trap));
                chk("a_bad", ia.bad_addr, e.bad);
                chk("a_cnt", 32'(ia.redir_cnt), 32'(e.cnt));
            end else begin
                chk("b_pc", ib.pc, e.pc);
                chk("b_flush", 32'(ib.flush), 32'(e.flush));
                chk("b_trap", 32'(ib.trap), 32'(e.trap));
                chk("b_bad", ib.bad_addr, e.bad);
                chk("b_cnt", 32'(ib.redir_cnt), 32'(e.cnt));
            end
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_a_pc"}, ia.pc, 32'h0);
        chk({tag, "_b_pc"}, ib.pc, 32'h100);
        chk({tag, "_flush"}, {30'd0, ia.flush, ib.flush}, 32'd0);
        chk({tag, "_trap"}, {30'd0, ia.trap, ib.trap}, 32'd0);
        chk({tag, "_a_bad"}, ia.bad_addr, 32'd0);
        chk({tag, "_b_bad"}, ib.bad_addr, 32'd0);
        chk({tag, "_cnt"}, 32'(ia.redir_cnt) | 32'(ib.redir_cnt), 32'd0);
    endtask

    initial begin
        logic [31:0] hold;
        logic [1:0] cexp [5];
        apply(f_stall(), f_stall());
        model_reset();
        #12;
        reset_check("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Word addressing: sequential count from reset.
        for (int i = 0; i < 5; i++) begin
            run(0, '0);
            chk("t1_seq_pc", ia.pc, 32'(i + 1));
        end

        // beq taken and not taken, reserved condition.
        run(0, f_jal(32'd3));
        run(0, f_br(3'b000, 1'b1, 1'b0, 1'b0, -32'sd3));
        chk("t2_beq_pc", ia.pc, 32'd5);
        chk("t2_beq_flush", 32'(ia.flush), 32'd1);
        run(0, f_jal(32'd3));
        run(0, f_br(3'b000, 1'b0, 1'b0, 1'b0, -32'sd3));
        chk("t2_nt_pc", ia.pc, 32'd9);
        chk("t2_nt_flush", 32'(ia.flush), 32'd0);
        run(0, f_br(3'b010, 1'b1, 1'b1, 1'b1, 32'd40));
        chk("t2_rsv_pc", ia.pc, 32'd10);

        // All condition codes under random flags.
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                run(0, f_br(3'(c), 1'($urandom), 1'($urandom), 1'($urandom), 32'($urandom_range(0, 64)) - 32'd32));
            end
        end

        // jalr beats jal; jal beats branch.
        begin
            in_t x = f_jalr(32'd50, 32'd2);
            x.jal = 1'b1;
            x.imm = 32'd2;
            run(0, x);
            chk("t_jalr_wins", ia.pc, 32'd52);
            x = f_br(3'b000, 1'b1, 1'b0, 1'b0, 32'd100);
            x.jal = 1'b1;
            run(0, x);
        end

        // Stall holds PC with pending jal, then the jump lands.
        hold = ia.pc;
        for (int i = 0; i < 3; i++) begin
            in_t x = f_jal(32'd20);
            x.stall = 1'b1;
            run(0, x);
            chk("t4_stall_pc", ia.pc, hold);
        end
        run(0, f_jal(32'd20));
        chk("t4_jump_pc", ia.pc, hold + 32'd20);

        // Byte addressing: misaligned jalr traps, aligned jalr and link.
        run(1, f_jalr(32'h203, 32'd0));
        chk("t3_trap_pc", ib.pc, 32'h10);
        chk("t3_trap", 32'(ib.trap), 32'd1);
        chk("t3_bad", ib.bad_addr, 32'h202);
        run(1, f_jal(32'hF0));
        chk("t3_link", ib.link, 32'h104);
        run(1, f_jalr(32'h205, 32'd0));
        chk("t3_jalr_pc", ib.pc, 32'h204);
        chk("t3_bad_hold", ib.bad_addr, 32'h202);
        run(1, f_br(3'b001, 1'b0, 1'b0, 1'b0, 32'd6));
        chk("t3_br_trap", 32'(ib.trap), 32'd1);
        run(1, '0);
        run(1, '0);

        // Word PC wraps from all-ones to zero without trapping.
        run(0, f_jal(32'hFFFF_FFFF - ia.pc));
        chk("t5_allones", ia.pc, 32'hFFFF_FFFF);
        run(0, '0);
        chk("t5_wrap_pc", ia.pc, 32'd0);
        chk("t5_wrap_trap", 32'(ia.trap), 32'd0);

        // Asynchronous reset between edges, issued while a redirect is in flight.
        run(1, f_jal(32'd8));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_check("mid");
        apply(f_stall(), f_stall());
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Redirect counter saturates at 3 on the CNT_W=2 unit.
`ifdef PC_PERF_EN
        cexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        cexp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        for (int i = 0; i < 5; i++) begin
            run(1, f_jal(32'd8));
            chk("t6_cnt", 32'(ib.redir_cnt), 32'(cexp[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
